chip_despreader: RTL and testbench
==================================

Name: chip_despreader

Overview:
- Receive-side counterpart of the transmit chip spreading: takes the recovered chip stream from cdr (o_data/o_flag) and rebuilds 4-bit Zigbee symbols.
- Operation: searches for preamble alignment, tracks 32-chip symbol boundaries, and picks the best of 16 PN sequences by sequential correlation.
- Delivers one nibble per symbol toward the nibble-side sink, with lock and error status.

Parameters:
- CHIP_LEN, 32, chips per symbol (fixed by the PN table; not meant to be overridden).
- THRESH, 26, minimum agreeing chips (0..32) to accept a symbol or declare lock.
- MAX_MISS, 2, consecutive sub-threshold symbols before lock is dropped (1..7).

Ports:
- inClock  in  1  system clock
- inReset  in  1  synchronous, active-high reset
- inChip  in  1  recovered chip value
- inChipValid  in  1  one-cycle strobe qualifying inChip
- outSymbol  out  4  decided symbol, valid with outValid
- outValid  out  1  one-cycle pulse, new symbol accepted
- outMatch  out  6  agreement count (0..32) of the winning sequence, valid with outValid or outSymbolError
- outSymbolError  out  1  one-cycle pulse, best match < THRESH while locked
- outLocked  out  1  high while in TRACK

Behaviour:
- Clock and reset:
  - One clock (inClock). inReset is synchronous and active-high.
  - Reset clears state to SEARCH, the shift register, the chip counter, the miss counter and all outputs. After reset: outSymbol=0, outValid=0, outMatch=0, outSymbolError=0, outLocked=0.
  - Reset asserted mid-compute aborts the compute with no output pulse.
- Chip capture:
  - On each inChipValid, the 32-bit shift register moves toward index 0 and inChip enters at index 31.
  - After 32 chips, reg[i] = c_i, with c0 the oldest chip.
  - inChipValid may assert on consecutive cycles.
- Sequence table (package): symbol 0 c0..c31 = 11011001110000110101001000101110.
  - Symbols 1..7 are symbol 0 cyclically delayed by 4k chips: seq_k[i] = seq_0[(i-4k) mod 32].
  - Symbols 8..15 are symbols 0..7 with every odd-index chip inverted.
- SEARCH:
  - On every chip, compute the agreement count (32 minus the popcount of the XOR) of the updated register against sequence 0.
  - If the count is >= THRESH: go to TRACK, set outLocked on the next cycle, clear the chip counter, and launch a compute on this register snapshot. The preamble symbol is emitted.
- TRACK:
  - The 5-bit chip counter increments per chip and wraps at 31 to 0.
  - On the chip that wraps the counter, snapshot the register and launch a compute.
- Compute:
  - A dedicated snapshot register is used, so capture continues during compute.
  - Candidates 0..15 are evaluated one per cycle, keeping the running best.
  - Ties go to the lower index (update only on strictly greater).
  - Latency: the strobe on the 32nd chip is cycle 0, the snapshot is taken at the cycle-0 edge, candidates are evaluated in cycles 1..16, and the result is registered so outValid or outSymbolError is high in cycle 17.
  - A symbol lasts at least 32 cycles, so computes never overlap.
- Result:
  - best >= THRESH: outValid=1, outSymbol=best index, outMatch=best, miss counter cleared.
  - Otherwise: outSymbolError=1, outSymbol holds its previous value, outMatch=best, miss counter +1.
  - If the miss counter reaches MAX_MISS: return to SEARCH with outLocked=0 the same cycle as the error pulse, and clear the miss and chip counters. The shift register is kept, so search resumes on the next chip.
  - outValid and outSymbolError are never high together.
- outSymbol and outMatch hold their values between pulses.

Decomposition:
- zigbee_pkg holds:
  - CHIP_LEN and the symbol width;
  - the 16x32 PN constant table;
  - the state enum {SEARCH, TRACK};
  - a popcount32 function.
- One sub-module, chip_correlator: takes the snapshot and a start pulse, runs the 16-cycle argmax, and returns best index, best count and done.
- The top level holds capture, counters and the FSM.

Test Plan:
- Reset, then 64 chips of sequence 0 with no gaps.
  - Expected: outLocked rises 1 cycle after the 32nd strobe.
  - Expected: outValid pulses twice, each with outSymbol=0 and outMatch=32.
  - Expected: the first pulse is 17 cycles after the 32nd strobe.
- Locked, then sequences 7, 8, 15 with a gap of 5 idle cycles between chips.
  - Expected: outSymbol=7, then 8, then 15, all with outMatch=32, one pulse each.
- Locked, then symbol 3 with chips 0, 10 and 20 flipped.
  - Expected: outValid, outSymbol=3, outMatch=29.
- Locked, then two symbols of sequence 5 with 8 chips flipped each.
  - Expected: outSymbolError pulses twice with outMatch=24.
  - Expected: outLocked=0 on the second error pulse, and no outValid.
  - Then a preamble of sequence 0: relock.
- Random chips while in SEARCH: expect no outValid.
- Preamble with inReset asserted 5 cycles after the 32nd strobe (mid-compute).
  - Expected: no pulse, outLocked=0 and outMatch=0 the next cycle.
  - Expected: a fresh 32-chip preamble after reset locks normally.

Source files
------------

// File: rtl/zigbee_pkg.sv
// Shared constants, PN table, state type and
// correlation helpers for the chip despreader.
package zigbee_pkg;

    localparam int CHIP_LEN = 32;
    localparam int SYM_W    = 4;

    // Symbol 0 written c0..c31, so c0 sits at the MSB here.
    localparam logic [31:0] SEQ0_TXT =
        32'b11011001110000110101001000101110;

    typedef enum logic {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } state_t;

    // Entry k occupies bits [32k+31:32k]; bit i of an entry is chip c_i.
    function automatic logic [511:0] build_pn();
        logic [31:0]  s0;
        logic [31:0]  sk;
        logic [63:0]  dbl;
        logic [511:0] t;
        for (int i = 0; i < 32; i++) begin
            s0[i] = SEQ0_TXT[31-i];
        end
        t = '0;
        for (int k = 0; k < 8; k++) begin
            dbl = {s0, s0} << (4 * k);
            sk  = dbl[63:32];
            t[k*32 +: 32]     = sk;
            t[(k+8)*32 +: 32] = sk ^ 32'hAAAA_AAAA;
        end
        return t;
    endfunction

    localparam logic [511:0] PN_TABLE = build_pn();

    function automatic logic [31:0] pn_seq(input logic [3:0] k);
        return PN_TABLE[{k, 5'd0} +: 32];
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [5:0] agree32(input logic [31:0] a,
                                           input logic [31:0] b);
        return 6'd32 - popcount32(a ^ b);
    endfunction

endpackage

// File: rtl/chip_despreader_if.sv
// Chip input strobe and symbol result bundle
// between the despreader and its neighbours.
interface chip_despreader_if;
    import zigbee_pkg::*;

    logic             inChip;
    logic             inChipValid;
    logic [SYM_W-1:0] outSymbol;
    logic             outValid;
    logic [5:0]       outMatch;
    logic             outSymbolError;
    logic             outLocked;

    modport slave (
        input  inChip,
        input  inChipValid,
        output outSymbol,
        output outValid,
        output outMatch,
        output outSymbolError,
        output outLocked
    );

    modport master (
        output inChip,
        output inChipValid,
        input  outSymbol,
        input  outValid,
        input  outMatch,
        input  outSymbolError,
        input  outLocked
    );

endinterface

// File: rtl/chip_correlator.sv
// Sequential argmax of a 32-chip snapshot over the
// 16 PN sequences, one candidate per cycle.
module chip_correlator
    import zigbee_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [CHIP_LEN-1:0] i_snap,
    output logic                o_done,
    output logic [SYM_W-1:0]    o_idx,
    output logic [5:0]          o_cnt
);

    logic [CHIP_LEN-1:0] r_snap;
    logic                r_busy;
    logic [SYM_W-1:0]    r_k;
    logic [SYM_W-1:0]    r_best_idx;
    logic [5:0]          r_best_cnt;
    logic [5:0]          w_cnt;
    logic                w_take;

    // Strictly greater keeps the lower index on ties.
    assign w_cnt  = agree32(r_snap, pn_seq(r_k));
    assign w_take = w_cnt > r_best_cnt;
    assign o_done = r_busy && (r_k == 4'd15);
    assign o_idx  = w_take ? r_k : r_best_idx;
    assign o_cnt  = w_take ? w_cnt : r_best_cnt;

    // Snapshot on start, then walk candidates keeping the running best.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_snap     <= '0;
            r_busy     <= 1'b0;
            r_k        <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end else if (i_start) begin
            r_snap     <= i_snap;
            r_busy     <= 1'b1;
            r_k        <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end else if (r_busy) begin
            r_best_idx <= o_idx;
            r_best_cnt <= o_cnt;
            r_k        <= r_k + 4'd1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/chip_despreader.sv
// Chip capture, preamble search, symbol tracking
// and result reporting around the correlator.
module chip_despreader
    import zigbee_pkg::*;
#(
    parameter int THRESH   = 26,
    parameter int MAX_MISS = 2
) (
    input logic              inClock,
    input logic              inReset,
    chip_despreader_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nx;
    logic [CHIP_LEN-1:0] r_shift;
    logic [CHIP_LEN-1:0] w_shift_nx;
    logic [4:0]          r_cnt;
    logic [2:0]          r_miss;
    logic [5:0]          w_pre_cnt;
    logic                w_pre_hit;
    logic                w_wrap;
    logic                w_start;
    logic                w_done;
    logic [SYM_W-1:0]    w_idx;
    logic [5:0]          w_best;
    logic                w_accept;
    logic                w_reject;
    logic                w_drop;
    logic                w_valid_nx;
    logic                w_err_nx;

    assign w_shift_nx = {bus.inChip, r_shift[CHIP_LEN-1:1]};
    assign w_pre_cnt  = agree32(w_shift_nx, pn_seq(4'd0));
    assign w_pre_hit  = bus.inChipValid && (r_state == SEARCH)
                        && (w_pre_cnt >= 6'(THRESH));
    assign w_wrap     = bus.inChipValid && (r_state == TRACK)
                        && (r_cnt == 5'(CHIP_LEN - 1));
    assign w_start    = w_pre_hit || w_wrap;

    chip_correlator u_corr (
        .i_clk   (inClock),
        .i_rst   (inReset),
        .i_start (w_start),
        .i_snap  (w_shift_nx),
        .o_done  (w_done),
        .o_idx   (w_idx),
        .o_cnt   (w_best)
    );

    assign w_accept = w_done && (w_best >= 6'(THRESH));
    assign w_reject = w_done && (w_best < 6'(THRESH));
    assign w_drop   = w_reject && ((r_miss + 3'd1) == 3'(MAX_MISS));

    assign bus.outLocked = (r_state == TRACK);

    // Chip shift register, newest chip enters at the top.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            r_shift <= '0;
        end else if (bus.inChipValid) begin
            r_shift <= w_shift_nx;
        end
    end

    // State register.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Lock on preamble, drop after too many misses.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            SEARCH: if (w_pre_hit) w_state_nx = TRACK;
            TRACK:  if (w_drop)    w_state_nx = SEARCH;
            default: w_state_nx = SEARCH;
        endcase
    end

    // Result pulses decoded from the correlator verdict.
    always_comb begin
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        if (r_state == TRACK) begin
            w_valid_nx = w_accept;
            w_err_nx   = w_reject;
        end
    end

    // Chip/miss counters and registered symbol outputs.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            r_cnt              <= '0;
            r_miss             <= '0;
            bus.outSymbol      <= '0;
            bus.outValid       <= 1'b0;
            bus.outMatch       <= '0;
            bus.outSymbolError <= 1'b0;
        end else begin
            bus.outValid       <= w_valid_nx;
            bus.outSymbolError <= w_err_nx;
            if (w_drop || w_pre_hit) begin
                r_cnt <= '0;
            end else if (bus.inChipValid && (r_state == TRACK)) begin
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_valid_nx) begin
                r_miss <= '0;
            end else if (w_err_nx) begin
                r_miss <= w_drop ? 3'd0 : r_miss + 3'd1;
            end
            if (w_valid_nx || w_err_nx) begin
                bus.outMatch <= w_best;
            end
            if (w_valid_nx) begin
                bus.outSymbol <= w_idx;
            end
        end
    end

endmodule

// File: tb/tb_chip_despreader.sv
// Self-checking bench for chip_despreader with a
// chip-level reference model and directed phases.
module tb_chip_despreader;

    localparam int TH  = 26;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chip_despreader_if bus();

    chip_despreader #(.THRESH(TH), .MAX_MISS(MAX)) dut (
        .inClock (clk),
        .inReset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    bit win [32];
    bit m_locked;
    int m_cnt, m_miss;
    bit m_pend;
    int m_due, m_pidx, m_pcnt;
    int exp_sym, exp_match;
    bit exp_valid, exp_err;

    int q_vsym[$];
    int q_vmatch[$];
    int q_ematch[$];
    int q_elock[$];
    int first_valid_t;
    int strobe_t;

    function automatic bit pn_chip(input int k, input int i);
        logic [31:0] s0;
        int j;
        bit c;
        s0 = 32'b11011001110000110101001000101110;
        j = (i - 4 * (k % 8) + 32) % 32;
        c = s0[31 - j];
        if (k >= 8 && (i % 2) == 1) c = ~c;
        return c;
    endfunction

    function automatic int agree_win(input int k);
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (win[i] == pn_chip(k, i)) n++;
        return n;
    endfunction

    function automatic bit would_lock(input bit c);
        int n = 0;
        for (int i = 0; i < 31; i++)
            if (win[i+1] == pn_chip(0, i)) n++;
        if (c == pn_chip(0, 31)) n++;
        return !m_locked && (n >= TH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input bit c, input bit r);
        bit fire;
        int best, bidx, a;
        t++;
        if (r) begin
            foreach (win[i]) win[i] = 1'b0;
            m_locked = 0; m_cnt = 0; m_miss = 0; m_pend = 0;
            exp_sym = 0; exp_match = 0; exp_valid = 0; exp_err = 0;
            return;
        end
        exp_valid = 0;
        exp_err   = 0;
        fire      = 0;
        if (v) begin
            for (int i = 0; i < 31; i++) win[i] = win[i+1];
            win[31] = c;
            if (!m_locked) begin
                if (agree_win(0) >= TH) begin
                    m_locked = 1; m_cnt = 0; fire = 1;
                end
            end else if (m_cnt == 31) begin
                m_cnt = 0; fire = 1;
            end else begin
                m_cnt++;
            end
        end
        if (m_pend && m_due == t) begin
            m_pend    = 0;
            exp_match = m_pcnt;
            if (m_pcnt >= TH) begin
                exp_valid = 1; exp_sym = m_pidx; m_miss = 0;
            end else begin
                exp_err = 1; m_miss++;
                if (m_miss == MAX) begin
                    m_locked = 0; m_miss = 0; m_cnt = 0;
                end
            end
        end
        if (fire) begin
            best = -1; bidx = 0;
            for (int k = 0; k < 16; k++) begin
                a = agree_win(k);
                if (a > best) begin best = a; bidx = k; end
            end
            m_pend = 1; m_pidx = bidx; m_pcnt = best;
            m_due  = t + 16;
        end
    endtask

    task automatic step(input bit v, input bit c, input bit r);
        bus.inChipValid = v;
        bus.inChip      = c;
        rst             = r;
        @(posedge clk);
        model_edge(v, c, r);
        #1;
        chk("valid",  bus.outValid,       exp_valid);
        chk("error",  bus.outSymbolError, exp_err);
        chk("locked", bus.outLocked,      m_locked);
        chk("symbol", bus.outSymbol,      exp_sym);
        chk("match",  bus.outMatch,       exp_match);
        if (bus.outValid === 1'b1) begin
            q_vsym.push_back(int'(bus.outSymbol));
            q_vmatch.push_back(int'(bus.outMatch));
            if (first_valid_t < 0) first_valid_t = t;
        end
        if (bus.outSymbolError === 1'b1) begin
            q_ematch.push_back(int'(bus.outMatch));
            q_elock.push_back(int'(bus.outLocked));
        end
        bus.inChipValid = 1'b0;
        bus.inChip      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic send_sym(input int k, input int gap,
                            input logic [31:0] flips);
        for (int i = 0; i < 32; i++) begin
            step(1, pn_chip(k, i) ^ flips[i], 0);
            if (i != 31) idle(gap);
        end
    endtask

    task automatic clear_q();
        q_vsym.delete(); q_vmatch.delete();
        q_ematch.delete(); q_elock.delete();
        first_valid_t = -1;
    endtask

    initial begin
        bus.inChip      = 1'b0;
        bus.inChipValid = 1'b0;
        clear_q();

        // Reset state
        repeat (3) step(0, 0, 1);
        chk("rst_valid",  bus.outValid, 0);
        chk("rst_err",    bus.outSymbolError, 0);
        chk("rst_locked", bus.outLocked, 0);
        chk("rst_symbol", bus.outSymbol, 0);
        chk("rst_match",  bus.outMatch, 0);

        // Preamble plus one more symbol 0, no gaps
        send_sym(0, 0, 32'h0);
        strobe_t = t;
        chk("p1_lock_rise", bus.outLocked, 1);
        send_sym(0, 0, 32'h0);
        idle(20);
        chk("p1_count", q_vsym.size(), 2);
        foreach (q_vsym[i]) begin
            chk("p1_sym", q_vsym[i], 0);
            chk("p1_match", q_vmatch[i], 32);
        end
        // Pulse in cycle 17 when the strobe cycle is cycle 0
        chk("p1_latency", first_valid_t - strobe_t, 16);

        // Gapped chips for symbols 7, 8, 15
        clear_q();
        send_sym(7, 5, 32'h0);
        send_sym(8, 5, 32'h0);
        send_sym(15, 5, 32'h0);
        idle(20);
        chk("p2_count", q_vsym.size(), 3);
        chk("p2_errs", q_ematch.size(), 0);
        if (q_vsym.size() == 3) begin
            chk("p2_sym0", q_vsym[0], 7);
            chk("p2_sym1", q_vsym[1], 8);
            chk("p2_sym2", q_vsym[2], 15);
            foreach (q_vmatch[i]) chk("p2_match", q_vmatch[i], 32);
        end

        // Symbol 3 with chips 0, 10, 20 flipped
        clear_q();
        send_sym(3, 0, 32'h0010_0401);
        idle(20);
        chk("p3_count", q_vsym.size(), 1);
        if (q_vsym.size() == 1) begin
            chk("p3_sym", q_vsym[0], 3);
            chk("p3_match", q_vmatch[0], 29);
        end

        // Two badly corrupted symbols 5 drop the lock
        clear_q();
        send_sym(5, 0, 32'h1111_1111);
        send_sym(5, 0, 32'h1111_1111);
        idle(20);
        chk("p4_valids", q_vsym.size(), 0);
        chk("p4_errs", q_ematch.size(), 2);
        if (q_ematch.size() == 2) begin
            chk("p4_match0", q_ematch[0], 24);
            chk("p4_match1", q_ematch[1], 24);
            chk("p4_lock0", q_elock[0], 1);
            chk("p4_lock1", q_elock[1], 0);
        end
        chk("p4_unlocked", bus.outLocked, 0);
        clear_q();
        send_sym(0, 0, 32'h0);
        idle(20);
        chk("p4_relock", bus.outLocked, 1);
        chk("p4_relock_cnt", q_vsym.size(), 1);

        // Random chips in SEARCH never lock or emit
        repeat (2) step(0, 0, 1);
        clear_q();
        for (int n = 0; n < 300; n++) begin
            bit c;
            c = 1'($urandom_range(0, 1));
            if (would_lock(c)) c = ~c;
            step(1, c, 0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(20);
        chk("p5_valids", q_vsym.size(), 0);
        chk("p5_locked", bus.outLocked, 0);

        // Reset in the middle of the preamble compute
        repeat (2) step(0, 0, 1);
        send_sym(7, 0, 32'h0);
        send_sym(0, 0, 32'h0);
        clear_q();
        chk("p6_locked", bus.outLocked, 1);
        idle(4);
        step(0, 0, 1);
        chk("p6_rst_locked", bus.outLocked, 0);
        chk("p6_rst_match", bus.outMatch, 0);
        idle(20);
        chk("p6_nopulse", q_vsym.size() + q_ematch.size(), 0);
        send_sym(0, 0, 32'h0);
        chk("p6_relock", bus.outLocked, 1);
        idle(20);
        chk("p6_count", q_vsym.size(), 1);
        if (q_vsym.size() == 1) begin
            chk("p6_sym", q_vsym[0], 0);
            chk("p6_match", q_vmatch[0], 32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
